// File: rtl/mux_8x1_rr_sched_pkg.sv
// Shared definitions for the round-robin 8:1 mux scheduler.
//   NUM_REQ / SEL_W : requester count and select width
//   state_e         : scheduler FSM encoding (IDLE / GRANT)
//   idx_to_onehot   : select index -> one-hot grant vector
package mux_8x1_rr_sched_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mux_8x1_rr_sched_mux.sv
// Plain 8:1 single-bit mux forming the shared datapath.
//   i : 8 data inputs
//   s : 3-bit select
//   y : selected bit i[s]
module mux_8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  assign y = i[s];

endmodule

// File: rtl/mux_8x1_rr_sched.sv
// Round-robin scheduler sharing one 8:1 mux among 8 requesters. One requester
// is granted at a time for a burst of up to BURST_LEN beats; the selected data
// bit is forwarded on dout while the granted requester keeps its request up.
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   en            : scheduler enable; low finishes the current grant, no new ones
//   req[7:0]      : level-sensitive requests
//   din[7:0]      : per-requester data bits (mux inputs)
//   gnt[7:0]      : registered one-hot grant, zero when idle
//   sel[2:0]      : registered mux select
//   dout          : din[sel] qualified by dout_vld
//   dout_vld      : grant active and req[sel] high this cycle
//   busy          : registered, high while in GRANT
module mux_8x1_rr_sched
  import mux_8x1_rr_sched_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [7:0]   req,
  input  logic [7:0]   din,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic         dout,
  output logic         dout_vld,
  output logic         busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  logic [SEL_W:0]       pick_idle_s;
  logic [SEL_W:0]       pick_rel_s;
  logic [SEL_W-1:0]     ptr_next_s;
  logic                 beat_s;
  logic                 release_s;
  logic                 raw_s;

  // Returns {found, index} of the first set request scanning ptr, ptr+1, ...
  // Iterating from the farthest offset down lets the nearest one win last.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [SEL_W-1:0]   p);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = {(SEL_W+1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = p + k[SEL_W-1:0];
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Next-state logic: arbitration, burst counting and release/re-arbitration.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ptr_next_s  = sel_q + 3'd1;
    pick_idle_s = rr_pick(req, ptr_q);
    // Release-time arbitration uses the post-release pointer, so the
    // current owner is considered last and a lone requester re-wins.
    pick_rel_s  = rr_pick(req, ptr_next_s);
    beat_s      = (state_q == ST_GRANT) && req[sel_q];
    release_s   = !req[sel_q] || (beat_s && (cnt_q == CNT_LAST)) || !en;

    case (state_q)
      ST_IDLE: begin
        if (en && pick_idle_s[SEL_W]) begin
          state_d = ST_GRANT;
          sel_d   = pick_idle_s[SEL_W-1:0];
          gnt_d   = idx_to_onehot(pick_idle_s[SEL_W-1:0]);
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
          gnt_d   = {NUM_REQ{1'b0}};
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          ptr_d = ptr_next_s;
          cnt_d = {CNT_W{1'b0}};
          if (en && pick_rel_s[SEL_W]) begin
            state_d = ST_GRANT;
            sel_d   = pick_rel_s[SEL_W-1:0];
            gnt_d   = idx_to_onehot(pick_rel_s[SEL_W-1:0]);
          end else begin
            // sel keeps its value so the last owner stays visible
            state_d = ST_IDLE;
            gnt_d   = {NUM_REQ{1'b0}};
          end
        end else begin
          // Not releasing implies req[sel] is high, i.e. this cycle is a beat
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    busy_d = (state_d == ST_GRANT);
  end

  // Scheduler state and registered outputs; reset abandons any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= {NUM_REQ{1'b0}};
      sel_q   <= {SEL_W{1'b0}};
      ptr_q   <= {SEL_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  mux_8x1 u_mux (
    .i (din),
    .s (sel_q),
    .y (raw_s)
  );

  assign dout_vld = (|gnt_q) & req[sel_q];
  assign dout     = raw_s & dout_vld;
  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux_8x1_rr_sched.sv
module tb_mux_8x1_rr_sched;

  localparam int LIMIT = 7 * 4 + 8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       dout;
  logic       dout_vld;
  logic       busy;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
    logic       dout;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wt[8];
  logic stim_done = 1'b0;

  mux_8x1_rr_sched #(.BURST_LEN(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .sel      (sel),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one vector at the falling edge; expectation describes the outputs
  // a moment later (registered state so far combined with these inputs).
  task automatic step(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] d,
                      input logic has, input logic [7:0] eg, input logic [2:0] es,
                      input logic ev, input logic ed, input logic eb);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; req = rq; din = d;
    if (has) begin
      x.gnt = eg; x.sel = es; x.vld = ev; x.dout = ed; x.busy = eb;
      exp_q.push_back(x);
    end
  endtask

  task automatic dstep(input logic r, input logic e, input logic [7:0] rq, input logic [7:0] d,
                       input logic [7:0] eg, input logic [2:0] es,
                       input logic ev, input logic ed, input logic eb);
    step(r, e, rq, d, 1'b1, eg, es, ev, ed, eb);
  endtask

  // Monitor: scoreboard pops plus per-cycle invariants.
  initial begin
    exp_t x;
    int   onehot_ok;
    for (int k = 0; k < 8; k++) wt[k] = 0;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("gnt", 32'(gnt), 32'(x.gnt));
        chk("sel", 32'(sel), 32'(x.sel));
        chk("dout_vld", 32'(dout_vld), 32'(x.vld));
        chk("dout", 32'(dout), 32'(x.dout));
        chk("busy", 32'(busy), 32'(x.busy));
      end
      if (!rst) begin
        onehot_ok = ((gnt & (gnt - 8'd1)) == 8'd0) ? 1 : 0;
        chk("gnt_onehot", 32'(onehot_ok), 32'd1);
        chk("dout_eq_mux", 32'(dout), 32'(din[sel] & dout_vld));
        chk("vld_rule", 32'(dout_vld), 32'((|gnt) & req[sel]));
        chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
        for (int k = 0; k < 8; k++) begin
          if (en && req[k] && !gnt[k]) wt[k] = wt[k] + 1;
          else wt[k] = 0;
          if (wt[k] > LIMIT) begin
            chk("starvation", 32'(wt[k]), 32'(LIMIT));
            wt[k] = 0;
          end
        end
      end else begin
        for (int k = 0; k < 8; k++) wt[k] = 0;
      end
    end
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus did not complete");
      $fatal(1, "timeout");
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00; din = 8'h00;

    // Reset state
    dstep(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Single requester 2: continuous grant across burst boundaries
    dstep(1'b0, 1'b1, 8'h04, 8'h04, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      dstep(1'b0, 1'b1, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-burst with all requests up
    dstep(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b1, 1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Rotation between requesters 0 and 7, no idle gap
    dstep(1'b0, 1'b1, 8'h81, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      dstep(1'b0, 1'b1, 8'h81, 8'h80, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      dstep(1'b0, 1'b1, 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      dstep(1'b0, 1'b1, 8'h81, 8'h80, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1);

    // Early drop by requester 1 after two beats
    dstep(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h06, 8'h06, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h06, 8'h06, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
    dstep(1'b0, 1'b1, 8'h06, 8'h06, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);
    dstep(1'b0, 1'b1, 8'h04, 8'h06, 8'h02, 3'd1, 1'b0, 1'b0, 1'b1);
    dstep(1'b0, 1'b1, 8'h04, 8'h06, 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);

    // Disable mid-burst, then re-enable: next grant starts at old sel+1
    dstep(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h03, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h03, 8'h03, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
    dstep(1'b0, 1'b0, 8'h03, 8'h03, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
    dstep(1'b0, 1'b0, 8'h03, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b0, 8'h03, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h03, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    dstep(1'b0, 1'b1, 8'h03, 8'h03, 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);

    // Random traffic checked by the monitor invariants
    for (int i = 0; i < 500; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #3;
    stim_done = 1'b1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
